ones_count_arb: RTL and testbench

ONES_COUNT_ARB -- requirements
Module: ones_count_arb

---
 rtl/ones_count_arb.sv | 138 +++++++++++++
 tb/tb_ones_count_arb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ones_count_arb.sv
// Two-requester round-robin front end to a 15-bit ones counter.
// Three-state FSM (IDLE/COUNT/RESP) gives one result every three cycles.

module oc_15 (
    input  logic [14:0] x_i,   // x_i[14] is the first counter input
    output logic        w3,
    output logic        w2,
    output logic        w1,
    output logic        w0
);

    logic [3:0] sum_s;

    // Population count of the 15 inputs
    always_comb begin
        sum_s = 4'd0;
        for (int i = 0; i < 15; i++) begin
            sum_s = sum_s + {3'd0, x_i[i]};
        end
    end

    assign {w3, w2, w1, w0} = sum_s;

endmodule

module ones_count_arb (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req0,
    input  logic        req1,
    input  logic [14:0] din0,
    input  logic [14:0] din1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [3:0]  count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] operand_q, operand_d;
    logic        id_q, id_d;
    logic        ptr_q, ptr_d;        // 1 = requester 1 is favoured
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic [3:0]  count_q, count_d;
    logic [3:0]  oc_sum_s;
    logic        sel1_s;

    oc_15 u_oc (
        .x_i (operand_q),
        .w3  (oc_sum_s[3]),
        .w2  (oc_sum_s[2]),
        .w1  (oc_sum_s[1]),
        .w0  (oc_sum_s[0])
    );

    // A lone requester wins outright; on contention the pointer decides
    assign sel1_s = req1 & (~req0 | ptr_q);

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            operand_q <= 15'd0;
            id_q      <= 1'b0;
            ptr_q     <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            count_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            count_q   <= count_d;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    operand_d = sel1_s ? din1 : din0;
                    id_d      = sel1_s;
                    gnt0_d    = ~sel1_s;
                    gnt1_d    = sel1_s;
                    state_d   = COUNT;
                end else begin
                    state_d   = IDLE;
                end
            end
            COUNT: begin
                count_d = oc_sum_s;
                state_d = RESP;
            end
            RESP: begin
                ptr_d   = ~id_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from registered state
    always_comb begin
        gnt0    = gnt0_q;
        gnt1    = gnt1_q;
        count   = count_q;
        busy    = (state_q != IDLE);
        done    = (state_q == RESP);
        if (state_q == RESP) begin
            done_id = id_q;
        end else begin
            done_id = 1'b0;
        end
    end

endmodule

// File: tb/tb_ones_count_arb.sv
// Directed self-checking bench for ones_count_arb; inputs change and
// outputs are sampled on the falling clock edge.

module tb_ones_count_arb;

    logic        clk;
    logic        rstn;
    logic        req0, req1;
    logic [14:0] din0, din1;
    logic        gnt0, gnt1, busy, done, done_id;
    logic [3:0]  count;

    int checks;
    int failures;

    ones_count_arb dut (
        .clk     (clk),
        .rstn    (rstn),
        .req0    (req0),
        .req1    (req1),
        .din0    (din0),
        .din1    (din1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [3:0] exp_count);
        check({tag, "_busy"}, {15'd0, busy}, 16'd0);
        check({tag, "_done"}, {15'd0, done}, 16'd0);
        check({tag, "_done_id"}, {15'd0, done_id}, 16'd0);
        check({tag, "_gnt0"}, {15'd0, gnt0}, 16'd0);
        check({tag, "_gnt1"}, {15'd0, gnt1}, 16'd0);
        check({tag, "_count"}, {12'd0, count}, {12'd0, exp_count});
    endtask

    // One isolated request from IDLE; request dropped right after its grant
    task automatic single_op(input string tag, input logic id, input logic [14:0] d,
                             input logic [3:0] exp_count);
        if (id) begin
            req1 = 1'b1;
            din1 = d;
        end else begin
            req0 = 1'b1;
            din0 = d;
        end
        tick();
        check({tag, "_gnt0"}, {15'd0, gnt0}, {15'd0, ~id});
        check({tag, "_gnt1"}, {15'd0, gnt1}, {15'd0, id});
        check({tag, "_busy1"}, {15'd0, busy}, 16'd1);
        check({tag, "_nodone"}, {15'd0, done}, 16'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check({tag, "_done"}, {15'd0, done}, 16'd1);
        check({tag, "_done_id"}, {15'd0, done_id}, {15'd0, id});
        check({tag, "_count"}, {12'd0, count}, {12'd0, exp_count});
        check({tag, "_gnt_off"}, {14'd0, gnt0, gnt1}, 16'd0);
        tick();
        check({tag, "_busy0"}, {15'd0, busy}, 16'd0);
        check({tag, "_done0"}, {15'd0, done}, 16'd0);
        check({tag, "_hold"}, {12'd0, count}, {12'd0, exp_count});
    endtask

    initial begin
        logic [14:0] walk;
        checks   = 0;
        failures = 0;
        rstn = 1'b0;
        req0 = 1'b1;             // reset must override a pending request
        req1 = 1'b1;
        din0 = 15'h1234;
        din1 = 15'h4321;
        @(negedge clk);
        tick();
        tick();
        check_idle_outputs("reset", 4'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        rstn = 1'b1;
        tick();
        check_idle_outputs("post_reset_idle", 4'd0);

        // Single request latency
        single_op("single0", 1'b0, 15'h0001, 4'd1);

        // Boundary values through requester 1
        single_op("max1", 1'b1, 15'h7FFF, 4'd15);
        single_op("zero1", 1'b1, 15'h0000, 4'd0);

        // Contention after reset: strict alternation 0,1,0,1
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        din0 = 15'h00FF;
        din1 = 15'h000F;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("cont_gnt0", {15'd0, gnt0}, (k % 2 == 0) ? 16'd1 : 16'd0);
            check("cont_gnt1", {15'd0, gnt1}, (k % 2 == 1) ? 16'd1 : 16'd0);
            check("cont_nodone", {15'd0, done}, 16'd0);
            tick();
            check("cont_done", {15'd0, done}, 16'd1);
            check("cont_done_id", {15'd0, done_id}, (k % 2 == 1) ? 16'd1 : 16'd0);
            check("cont_count", {12'd0, count}, (k % 2 == 0) ? 16'd8 : 16'd4);
            check("cont_gnt_off", {14'd0, gnt0, gnt1}, 16'd0);
            tick();
            check("cont_idle", {15'd0, busy}, 16'd0);
            check("cont_idle_done", {15'd0, done}, 16'd0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();

        // Request arriving while busy is dropped, not queued
        req0 = 1'b1;
        din0 = 15'h0003;
        tick();
        check("busy_gnt0", {15'd0, gnt0}, 16'd1);
        req0 = 1'b0;
        req1 = 1'b1;
        din1 = 15'h7FFF;
        tick();
        check("busy_gnt1_a", {15'd0, gnt1}, 16'd0);
        check("busy_done", {15'd0, done}, 16'd1);
        check("busy_done_id", {15'd0, done_id}, 16'd0);
        check("busy_count", {12'd0, count}, 16'd2);
        req1 = 1'b0;
        tick();
        check("busy_gnt1_b", {15'd0, gnt1}, 16'd0);
        check("busy_idle", {15'd0, busy}, 16'd0);
        tick();
        check("busy_gnt1_c", {15'd0, gnt1}, 16'd0);
        check("busy_still_idle", {15'd0, busy}, 16'd0);

        // Reset during COUNT abandons the operation
        req0 = 1'b1;
        din0 = 15'h0007;
        tick();
        check("rmid_gnt0", {15'd0, gnt0}, 16'd1);
        rstn = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        check_idle_outputs("rmid_after", 4'd0);
        tick();
        check("rmid_nodone", {15'd0, done}, 16'd0);
        rstn = 1'b1;
        din0 = 15'h00FF;
        din1 = 15'h000F;
        tick();
        check("rmid_first_gnt0", {15'd0, gnt0}, 16'd1);
        check("rmid_first_gnt1", {15'd0, gnt1}, 16'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check("rmid_done", {15'd0, done}, 16'd1);
        check("rmid_done_id", {15'd0, done_id}, 16'd0);
        check("rmid_count", {12'd0, count}, 16'd8);
        tick();

        // Walking ones from bit 14 downwards
        walk = 15'h0000;
        for (int n = 0; n <= 15; n++) begin
            single_op("walk", 1'b0, walk, n[3:0]);
            walk = {1'b1, walk[14:1]};
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
